// File: rtl/pipe_ctrl_pkg.sv
// Shared stall encodings, address types and stall-vector patterns for pipe_ctrl.
`timescale 1ns/1ps
package pipe_ctrl_pkg;
    typedef logic [1:0] StallBus;
    localparam StallBus Pass = 2'b00;
    localparam StallBus Hold = 2'b01;
    localparam StallBus Bubb = 2'b10;

    localparam int INST_ADDR_W = 32;
    typedef logic [INST_ADDR_W-1:0] InstAddrBus;
    localparam InstAddrBus ZeroWord = '0;

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

    typedef struct packed {
        StallBus pc;
        StallBus if_id;
        StallBus id_ex;
        StallBus ex_mem;
        StallBus mem_wb;
    } stall_vec_t;

    // Canonical stall patterns, one per scheduler decision
    localparam stall_vec_t SV_ALL_PASS = '{Pass, Pass, Pass, Pass, Pass};
    localparam stall_vec_t SV_ALL_BUBB = '{Bubb, Bubb, Bubb, Bubb, Bubb};
    localparam stall_vec_t SV_MEM_HOLD = '{Hold, Hold, Hold, Hold, Bubb};
    localparam stall_vec_t SV_REDIRECT = '{Pass, Bubb, Bubb, Pass, Pass};
    localparam stall_vec_t SV_LOAD_USE = '{Hold, Hold, Bubb, Pass, Pass};
    localparam stall_vec_t SV_FETCH    = '{Hold, Bubb, Pass, Pass, Pass};
endpackage

// File: rtl/pipe_ctrl_perf.sv
// Stall-cycle and redirect counters for pipe_ctrl; wrap at 2^CNT_W, cleared by rst.
`timescale 1ns/1ps
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stall_i);
        flush_cnt_d = flush_cnt_q + CNT_W'(flush_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline; holds a redirect raised during a MEM stall.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
`timescale 1ns/1ps
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_if,
    input  logic              req_id,
    input  logic              req_mem,
    input  logic              branch_error_i,
    input  logic [ADDR_W-1:0] branch_npc_i,
    output logic [1:0]        stall_pc,
    output logic [1:0]        stall_if_id,
    output logic [1:0]        stall_id_ex,
    output logic [1:0]        stall_ex_mem,
    output logic [1:0]        stall_mem_wb,
    output logic              branch_error_o,
    output logic [ADDR_W-1:0] branch_npc_o,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    stall_vec_t        sv;

    always_comb begin
        sv             = SV_ALL_PASS;
        branch_error_o = 1'b0;
        branch_npc_o   = '0;
        state_d        = state_q;
        npc_d          = npc_q;
        if (rst) begin
            sv = SV_ALL_BUBB;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (req_mem) begin
                        sv = SV_MEM_HOLD;
                        // EX is frozen, so the redirect waits until MEM drains
                        if (branch_error_i) begin
                            npc_d   = branch_npc_i;
                            state_d = PEND;
                        end
                    end else if (branch_error_i) begin
                        sv             = SV_REDIRECT;
                        branch_error_o = 1'b1;
                        branch_npc_o   = branch_npc_i;
                    end else if (req_id) begin
                        sv = SV_LOAD_USE;
                    end else if (req_if) begin
                        sv = SV_FETCH;
                    end
                end
                PEND: begin
                    // The held EX instruction may re-raise branch_error_i; ignore it
                    if (req_mem) begin
                        sv = SV_MEM_HOLD;
                    end else begin
                        sv             = SV_REDIRECT;
                        branch_error_o = 1'b1;
                        branch_npc_o   = npc_q;
                        state_d        = RUN;
                        npc_d          = '0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
        end
    end

    assign stall_pc     = sv.pc;
    assign stall_if_id  = sv.if_id;
    assign stall_id_ex  = sv.id_ex;
    assign stall_ex_mem = sv.ex_mem;
    assign stall_mem_wb = sv.mem_wb;

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (sv.pc != Pass),
        .flush_i     (branch_error_o),
        .stall_cnt_o (perf_stall_cnt),
        .flush_cnt_o (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, corner sequences, random run vs. a queue model.
`timescale 1ns/1ps
module tb_pipe_ctrl;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_if = 1'b0, req_id = 1'b0, req_mem = 1'b0, branch_error_i = 1'b0;
    logic [ADDR_W-1:0] branch_npc_i = '0;
    logic [1:0]        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic              branch_error_o;
    logic [ADDR_W-1:0] branch_npc_o;
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;

    pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_if(req_if), .req_id(req_id), .req_mem(req_mem),
        .branch_error_i(branch_error_i), .branch_npc_i(branch_npc_i),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .branch_error_o(branch_error_o), .branch_npc_o(branch_npc_o),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // Stall codes packed pc,if_id,id_ex,ex_mem,mem_wb (P=00 H=01 B=10)
    localparam logic [9:0] ST_PASS  = 10'b00_00_00_00_00;
    localparam logic [9:0] ST_BUBB  = 10'b10_10_10_10_10;
    localparam logic [9:0] ST_MEMH  = 10'b01_01_01_01_10;
    localparam logic [9:0] ST_REDIR = 10'b00_10_10_00_00;
    localparam logic [9:0] ST_LDUSE = 10'b01_01_10_00_00;
    localparam logic [9:0] ST_FETCH = 10'b01_10_00_00_00;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: outstanding redirects still owed to the PC, plus perf tallies
    logic [ADDR_W-1:0] owed[$];
    int unsigned       m_stalls = 0;
    int unsigned       m_flushes = 0;

    typedef struct {
        logic ri, rd, rm, be;
        logic [31:0] npc;
        logic [9:0]  st;
        logic        xbe;
        logic [31:0] xnpc;
    } vec_t;

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [42:0] model_out();
        if (rst)                        return {ST_BUBB, 1'b0, 32'h0};
        if (req_mem)                    return {ST_MEMH, 1'b0, 32'h0};
        if (owed.size() != 0)           return {ST_REDIR, 1'b1, owed[0]};
        if (branch_error_i)             return {ST_REDIR, 1'b1, branch_npc_i};
        if (req_id)                     return {ST_LDUSE, 1'b0, 32'h0};
        if (req_if)                     return {ST_FETCH, 1'b0, 32'h0};
        return {ST_PASS, 1'b0, 32'h0};
    endfunction

    function automatic logic [42:0] dut_out();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                branch_error_o, branch_npc_o};
    endfunction

    task automatic check_model(input string nm);
        logic [63:0] xperf;
`ifdef PIPE_CTRL_PERF_EN
        xperf = rst ? 64'h0 : {m_stalls, m_flushes};
`else
        xperf = 64'h0;
`endif
        cmp(nm, {21'h0, dut_out()}, {21'h0, model_out()});
        cmp({nm, "_perf"}, {perf_stall_cnt, perf_flush_cnt}, xperf);
    endtask

    task automatic drive(input logic r, input logic ri, input logic rd, input logic rm,
                         input logic be, input logic [31:0] npc);
        @(negedge clk);
        rst = r; req_if = ri; req_id = rd; req_mem = rm;
        branch_error_i = be; branch_npc_i = npc;
        #1;
    endtask

    task automatic tick();
        logic [42:0] o;
        o = model_out();
        @(posedge clk);
        if (rst) begin
            owed.delete();
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            if (o[42:41] != 2'b00) m_stalls++;
            if (o[32]) begin
                m_flushes++;
                if (owed.size() != 0) void'(owed.pop_front());
            end else if (req_mem && branch_error_i && owed.size() == 0) begin
                owed.push_back(branch_npc_i);
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    ST_PASS,  1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    ST_FETCH, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    ST_LDUSE, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,    ST_LDUSE, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h100,  ST_REDIR, 1'b1, 32'h100};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, ST_REDIR, 1'b1, 32'h1234};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    ST_MEMH,  1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,    ST_MEMH,  1'b0, 32'h0};

        // Async reset asserted mid-clock
        @(posedge clk); #2;
        rst = 1'b1; #1;
        cmp("rst_async", {21'h0, dut_out()}, {21'h0, ST_BUBB, 1'b0, 32'h0});
        check_model("rst_model");
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cmp("rst_release", {21'h0, dut_out()}, {21'h0, ST_PASS, 1'b0, 32'h0});
        tick();

        // Single-cycle decisions from RUN
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vecs[i].ri, vecs[i].rd, vecs[i].rm, vecs[i].be, vecs[i].npc);
            cmp($sformatf("vec%0d", i), {21'h0, dut_out()},
                {21'h0, vecs[i].st, vecs[i].xbe, vecs[i].xnpc});
            check_model($sformatf("vec%0d_model", i));
            tick();
        end

        // Load-use for one cycle, then clear
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cmp("lduse", {21'h0, dut_out()}, {21'h0, ST_LDUSE, 1'b0, 32'h0});
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cmp("lduse_after", {21'h0, dut_out()}, {21'h0, ST_PASS, 1'b0, 32'h0});
        tick();

        // Branch during MEM stall: 0x200 held, 0x300 and a PEND re-assert ignored
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        cmp("pend_c1", {21'h0, dut_out()}, {21'h0, ST_MEMH, 1'b0, 32'h0});
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300);
        cmp("pend_c2", {21'h0, dut_out()}, {21'h0, ST_MEMH, 1'b0, 32'h0});
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cmp("pend_c3", {21'h0, dut_out()}, {21'h0, ST_MEMH, 1'b0, 32'h0});
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        cmp("pend_c4_redirect", {21'h0, dut_out()}, {21'h0, ST_REDIR, 1'b1, 32'h200});
        check_model("pend_c4_model");
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cmp("pend_c5", {21'h0, dut_out()}, {21'h0, ST_PASS, 1'b0, 32'h0});
        tick();

        // Reset while a redirect is pending drops it
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cmp("pend_rst", {21'h0, dut_out()}, {21'h0, ST_BUBB, 1'b0, 32'h0});
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            cmp($sformatf("pend_rst_after%0d", i), {21'h0, dut_out()},
                {21'h0, ST_PASS, 1'b0, 32'h0});
            tick();
        end

        // Perf: 5 fetch stalls, then 2 redirects
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h500 + 32'(i * 4));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        cmp("perf_counts", {perf_stall_cnt, perf_flush_cnt}, {32'd5, 32'd2});
`else
        cmp("perf_tied", {perf_stall_cnt, perf_flush_cnt}, 64'h0);
`endif
        check_model("perf_model");
        tick();

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 60) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom & 32'hFFFF_FFFC);
            check_model($sformatf("rand%0d", i));
            if (branch_error_o && stall_pc != 2'b00) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand%0d_redir_vs_stall: stall_pc %b with branch_error_o=1", i, stall_pc);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RISC-V pipeline. It collects hazard requests from IF, ID, MEM and the EX branch-resolution result, and drives one stall code to each stage register: pc, if_id, id_ex, ex_mem and mem_wb. It also drives the redirect pair (branch_error/branch_npc) into the PC register. It holds a mispredict redirect that arrives while MEM is stalled until the pipeline can accept it.

Parameters:
ADDR_W, 32, instruction address width.
CNT_W, 32, perf counter width (used only with PIPE_CTRL_PERF_EN).

Ports:
clk  in  1  clock (one clock domain).
rst  in  1  asynchronous, active-high reset.
req_if  in  1  fetch not ready (icache miss or bus busy).
req_id  in  1  load-use hazard detected in ID.
req_mem  in  1  data memory busy; MEM cannot retire this cycle.
branch_error_i  in  1  EX resolved a mispredict/jump this cycle.
branch_npc_i  in  ADDR_W  correct next PC, valid with branch_error_i.
stall_pc  out  2  stall code for the PC register.
stall_if_id  out  2  stall code for the IF/ID register.
stall_id_ex  out  2  stall code for the ID/EX register.
stall_ex_mem  out  2  stall code for the EX/MEM register.
stall_mem_wb  out  2  stall code for the MEM/WB register.
branch_error_o  out  1  redirect strobe to the PC register.
branch_npc_o  out  ADDR_W  redirect target; 0 when branch_error_o=0.
perf_stall_cnt  out  CNT_W  cycles with stall_pc!=Pass (perf build only).
perf_flush_cnt  out  CNT_W  redirects issued (perf build only).

Behaviour:
- Stall codes: Pass=2'b00 (load), Hold=2'b01 (keep), Bubb=2'b10 (clear to zero/NOP).
- All stall/redirect outputs are combinational from the current state and inputs, so they act in the same cycle. State is registered.
- FSM states: RUN and PEND. A pending-redirect register npc_q holds ADDR_W bits.
- Reset (async, rst=1):
  - state=RUN, npc_q=0.
  - While rst=1: all five stall outputs=Bubb, branch_error_o=0, branch_npc_o=0, perf counters=0.
- RUN, priority highest first:
  1. req_mem: pc, if_id, id_ex and ex_mem = Hold; mem_wb = Bubb. If branch_error_i is also 1: capture npc_q<=branch_npc_i and go to PEND. No redirect is output this cycle.
  2. branch_error_i: pc=Pass with branch_error_o=1 and branch_npc_o=branch_npc_i; if_id=Bubb; id_ex=Bubb; ex_mem=Pass; mem_wb=Pass. req_id and req_if are ignored.
  3. req_id: pc=Hold, if_id=Hold, id_ex=Bubb, ex_mem=Pass, mem_wb=Pass.
  4. req_if: pc=Hold, if_id=Bubb, id_ex/ex_mem/mem_wb=Pass.
  5. Otherwise all five = Pass.
- PEND:
  - branch_error_i and branch_npc_i are ignored; the held EX instruction may re-assert them.
  - While req_mem=1: same outputs as RUN rule 1.
  - First cycle req_mem=0: issue the redirect from npc_q with the rule-2 outputs; go to RUN; npc_q<=0.
- Latency:
  - Redirect reaches the PC register in the same cycle as branch_error_i (RUN), or in the first cycle after req_mem falls (PEND).
  - Exactly one redirect is issued per mispredict.
- Reset mid-PEND drops the pending redirect (npc_q cleared).
- branch_error_o is never 1 together with stall_pc!=Pass.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every non-reset cycle with stall_pc!=Pass.
  - perf_flush_cnt increments on every cycle with branch_error_o=1.
  - Both wrap at 2^CNT_W and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared defines package: StallBus (1:0), Pass, Hold, Bubb encodings, InstAddrBus, ZeroWord.
- One natural sub-module: pipe_ctrl_perf, holding the two counters and instantiated only under PIPE_CTRL_PERF_EN.
- The FSM and priority logic stay in pipe_ctrl.

Test Plan:
- Reset: rst pulse asserted mid-clock -> all stalls=Bubb immediately; after release, no requests -> all Pass, branch_error_o=0.
- Branch in RUN: branch_error_i=1, npc=0x0000_0100, req_if=1 -> pc=Pass, branch_error_o=1, npc_o=0x100, if_id=Bubb, id_ex=Bubb, ex_mem=Pass.
- Load-use: req_id=1 for 1 cycle -> pc=Hold, if_id=Hold, id_ex=Bubb, ex_mem/mem_wb=Pass; next cycle all Pass.
- Branch during mem stall: req_mem=1 for 3 cycles, branch_error_i=1 with npc=0x200 on cycle 1, then 0x300 on cycle 2 -> cycles 1-3 pc..ex_mem=Hold, mem_wb=Bubb, no redirect; cycle 4 single redirect to 0x200 (0x300 ignored); cycle 5 all Pass.
- Reset during PEND: capture npc=0x400, assert rst, release with req_mem=0 -> no redirect ever issued.
- Perf (PIPE_CTRL_PERF_EN): 5 cycles req_if, then 2 branch redirects -> perf_stall_cnt=5, perf_flush_cnt=2.
